// File: rtl/trap_seq_ctrl.sv
// trap_seq_ctrl: exception / interrupt / MRET sequencer for the 5-stage core.
//
// Takes one event from the MEM stage, waits for the outstanding data access
// to drain, flushes the pipeline registers, writes mepc and mcause through
// the WB-stage CSR write port (traps only), then redirects the PC to mtvec
// for a trap or to mepc for MRET.
//
// Optional build macro TRAP_CNT_EN adds a 32-bit trap_count output that
// counts the traps that reach REDIRECT. MRET sequences are not counted.
//
// Interface contract: there is no valid/ready handshake here. The event
// inputs are level samples taken only while the sequencer is idle
// (busy=0). Every output is a single-cycle strobe or a value qualified by
// its strobe: trap_waddr_csr/trap_wdata_csr mean something only while
// trap_wr_csr=1, and redirect_pc only while pc_redirect=1. Both are driven
// to 0 otherwise.

module trap_seq_ctrl #(
  parameter int          DRAIN_MAX  = 15,
  parameter logic [11:0] CSR_MEPC   = 12'h341,
  parameter logic [11:0] CSR_MCAUSE = 12'h342
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        me_exc_valid,
  input  logic [4:0]  me_exc_cause,
  input  logic [31:0] me_pc,
  input  logic        me_mret,
  input  logic        irq_ext,
  input  logic        irq_en,
  input  logic        mem_busy,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        stall_all,
  output logic        if_flush,
  output logic        id_flush,
  output logic        ex_flush,
  output logic        me_wb_flush,
  output logic        trap_wr_csr,
  output logic [11:0] trap_waddr_csr,
  output logic [31:0] trap_wdata_csr,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        drain_timeout,
`ifdef TRAP_CNT_EN
  output logic [31:0] trap_count,
`endif
  output logic        busy
);

  // Sequencer states. The encoding is visible to anyone probing the
  // hierarchy through the state_t-typed 'state' register.
  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DRAIN      = 3'd1,
    S_FLUSH      = 3'd2,
    S_SAVE_EPC   = 3'd3,
    S_SAVE_CAUSE = 3'd4,
    S_REDIRECT   = 3'd5
  } state_t;

  // What the captured event will do once the pipeline is clean.
  typedef enum logic {
    KIND_TRAP = 1'b0,
    KIND_RET  = 1'b1
  } kind_t;

  // The drain counter only has to hold values up to DRAIN_MAX-1: the last
  // allowed DRAIN cycle is the one where the counter equals DRAIN_MAX-1.
  localparam int CNT_W = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  // Interrupt cause: bit 31 set, code 11 (machine external interrupt).
  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

  state_t           state;
  state_t           state_d;
  kind_t            kind;
  logic [31:0]      epc;
  logic [31:0]      cause;
  logic [CNT_W-1:0] drain_cnt;

  logic             evt_exc;
  logic             evt_irq;
  logic             evt_ret;
  logic             evt_any;
  logic             drain_expired;
  logic [31:0]      trap_target;

  // Event qualification and next-state selection.
  always_comb begin
    evt_exc       = me_exc_valid;
    evt_irq       = irq_ext & irq_en;
    evt_ret       = me_mret;
    evt_any       = evt_exc | evt_irq | evt_ret;
    // Only a still-busy memory can time out; an access that finishes on
    // the last allowed cycle is a normal drain.
    drain_expired = mem_busy && (drain_cnt == DRAIN_LAST);
    trap_target   = {csr_mtvec[31:2], 2'b00};
    state_d       = state;
    case (state)
      S_IDLE: begin
        if (evt_any) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!mem_busy || drain_expired) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        state_d = (kind == KIND_TRAP) ? S_SAVE_EPC : S_REDIRECT;
      end
      S_SAVE_EPC: begin
        state_d = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, captured event, drain counter and registered outputs.
  // Outputs are loaded from the next state so that each one is asserted
  // exactly during the state it belongs to, straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      kind           <= KIND_TRAP;
      epc            <= '0;
      cause          <= '0;
      drain_cnt      <= '0;
      drain_timeout  <= 1'b0;
      stall_all      <= 1'b0;
      if_flush       <= 1'b0;
      id_flush       <= 1'b0;
      ex_flush       <= 1'b0;
      me_wb_flush    <= 1'b0;
      trap_wr_csr    <= 1'b0;
      trap_waddr_csr <= '0;
      trap_wdata_csr <= '0;
      pc_redirect    <= 1'b0;
      redirect_pc    <= '0;
      busy           <= 1'b0;
`ifdef TRAP_CNT_EN
      trap_count     <= '0;
`endif
    end else begin
      state <= state_d;

      // Event capture: exception beats interrupt beats MRET. Losers in
      // the same cycle are simply dropped; a level irq comes back later.
      if (state == S_IDLE) begin
        if (evt_exc) begin
          kind  <= KIND_TRAP;
          epc   <= me_pc;
          cause <= {27'b0, me_exc_cause};
        end else if (evt_irq) begin
          kind  <= KIND_TRAP;
          epc   <= me_pc;
          cause <= IRQ_CAUSE;
        end else if (evt_ret) begin
          kind  <= KIND_RET;
        end
      end

      // The counter runs only while staying in DRAIN, so it is zero on
      // every entry into DRAIN.
      if (state == S_DRAIN && state_d == S_DRAIN) begin
        drain_cnt <= drain_cnt + CNT_W'(1);
      end else begin
        drain_cnt <= '0;
      end

      // Sticky record that a drain was abandoned with memory still busy.
      if (state == S_DRAIN && drain_expired) begin
        drain_timeout <= 1'b1;
      end

      // Freeze while waiting on memory and while the CSR writes happen;
      // FLUSH and REDIRECT let the flushed / redirected registers move.
      stall_all   <= (state_d == S_DRAIN) || (state_d == S_SAVE_EPC) ||
                     (state_d == S_SAVE_CAUSE);

      // FLUSH clears every pipeline register; REDIRECT clears IF again so
      // the instruction fetched from the old PC is discarded.
      if_flush    <= (state_d == S_FLUSH) || (state_d == S_REDIRECT);
      id_flush    <= (state_d == S_FLUSH);
      ex_flush    <= (state_d == S_FLUSH);
      me_wb_flush <= (state_d == S_FLUSH);

      // CSR write port: address and data are zero when not writing.
      trap_wr_csr <= (state_d == S_SAVE_EPC) || (state_d == S_SAVE_CAUSE);
      if (state_d == S_SAVE_EPC) begin
        trap_waddr_csr <= CSR_MEPC;
        trap_wdata_csr <= epc;
      end else if (state_d == S_SAVE_CAUSE) begin
        trap_waddr_csr <= CSR_MCAUSE;
        trap_wdata_csr <= cause;
      end else begin
        trap_waddr_csr <= '0;
        trap_wdata_csr <= '0;
      end

      // The redirect target is sampled on the edge into REDIRECT. mtvec
      // is never written by this sequence and mepc is only written on
      // the trap path, which does not read it back.
      pc_redirect <= (state_d == S_REDIRECT);
      if (state_d == S_REDIRECT) begin
        redirect_pc <= (kind == KIND_TRAP) ? trap_target : csr_mepc;
      end else begin
        redirect_pc <= '0;
      end

      busy <= (state_d != S_IDLE);

`ifdef TRAP_CNT_EN
      // Count traps as they enter REDIRECT; MRET never counts. Wraps.
      if (state != S_REDIRECT && state_d == S_REDIRECT &&
          kind == KIND_TRAP) begin
        trap_count <= trap_count + 32'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Testbench for trap_seq_ctrl: directed sequences with a plan-based model
// (each event expands into an ordered list of sequence steps) checked on
// every falling clock edge, plus literal spot checks per scenario.

`timescale 1ns/1ps

module tb_trap_seq_ctrl;

  localparam int DRAIN_MAX = 15;

  localparam int ST_DRAIN = 1;
  localparam int ST_FLUSH = 2;
  localparam int ST_EPC   = 3;
  localparam int ST_CAUSE = 4;
  localparam int ST_REDIR = 5;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        me_exc_valid;
  logic [4:0]  me_exc_cause;
  logic [31:0] me_pc;
  logic        me_mret;
  logic        irq_ext;
  logic        irq_en;
  logic        mem_busy;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic        stall_all;
  logic        if_flush;
  logic        id_flush;
  logic        ex_flush;
  logic        me_wb_flush;
  logic        trap_wr_csr;
  logic [11:0] trap_waddr_csr;
  logic [31:0] trap_wdata_csr;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        drain_timeout;
  logic        busy;
`ifdef TRAP_CNT_EN
  logic [31:0] trap_count;
`endif

  trap_seq_ctrl #(
    .DRAIN_MAX  (DRAIN_MAX),
    .CSR_MEPC   (12'h341),
    .CSR_MCAUSE (12'h342)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .me_exc_valid   (me_exc_valid),
    .me_exc_cause   (me_exc_cause),
    .me_pc          (me_pc),
    .me_mret        (me_mret),
    .irq_ext        (irq_ext),
    .irq_en         (irq_en),
    .mem_busy       (mem_busy),
    .csr_mtvec      (csr_mtvec),
    .csr_mepc       (csr_mepc),
    .stall_all      (stall_all),
    .if_flush       (if_flush),
    .id_flush       (id_flush),
    .ex_flush       (ex_flush),
    .me_wb_flush    (me_wb_flush),
    .trap_wr_csr    (trap_wr_csr),
    .trap_waddr_csr (trap_waddr_csr),
    .trap_wdata_csr (trap_wdata_csr),
    .pc_redirect    (pc_redirect),
    .redirect_pc    (redirect_pc),
    .drain_timeout  (drain_timeout),
`ifdef TRAP_CNT_EN
    .trap_count     (trap_count),
`endif
    .busy           (busy)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // The model holds the remaining steps of the current sequence; an empty
  // list means idle.
  int          steps[$];
  logic        m_trap;
  logic [31:0] m_epc;
  logic [31:0] m_cause;
  int          m_drain_n;
  logic        m_timeout;
  logic [31:0] m_count;

  logic        e_stall, e_if, e_fl, e_wr, e_redir, e_busy;
  logic [11:0] e_addr;
  logic [31:0] e_data, e_rpc;

  task automatic plan(input logic is_trap, input logic [31:0] epc_v,
                      input logic [31:0] cause_v);
    m_trap    = is_trap;
    m_epc     = epc_v;
    m_cause   = cause_v;
    m_drain_n = 0;
    steps.delete();
    steps.push_back(ST_DRAIN);
    steps.push_back(ST_FLUSH);
    if (is_trap) begin
      steps.push_back(ST_EPC);
      steps.push_back(ST_CAUSE);
    end
    steps.push_back(ST_REDIR);
  endtask

  task automatic step_done();
    void'(steps.pop_front());
    m_drain_n = 0;
    if (steps.size() != 0 && steps[0] == ST_REDIR && m_trap) begin
      m_count = m_count + 32'd1;
    end
  endtask

  // Compare process: expectations from the model, then model advance using
  // the inputs the DUT will sample on the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      steps.delete();
      m_trap    = 1'b0;
      m_epc     = '0;
      m_cause   = '0;
      m_drain_n = 0;
      m_timeout = 1'b0;
      m_count   = '0;
    end
    e_stall = 1'b0; e_if = 1'b0; e_fl = 1'b0; e_wr = 1'b0; e_redir = 1'b0;
    e_addr = '0; e_data = '0; e_rpc = '0;
    e_busy = (steps.size() != 0);
    if (steps.size() != 0) begin
      case (steps[0])
        ST_DRAIN: e_stall = 1'b1;
        ST_FLUSH: begin e_if = 1'b1; e_fl = 1'b1; end
        ST_EPC:   begin e_stall = 1'b1; e_wr = 1'b1; e_addr = 12'h341; e_data = m_epc; end
        ST_CAUSE: begin e_stall = 1'b1; e_wr = 1'b1; e_addr = 12'h342; e_data = m_cause; end
        ST_REDIR: begin
          e_redir = 1'b1;
          e_if    = 1'b1;
          e_rpc   = m_trap ? {csr_mtvec[31:2], 2'b00} : csr_mepc;
        end
        default: ;
      endcase
    end
    chk("stall_all",      32'(stall_all),      32'(e_stall));
    chk("if_flush",       32'(if_flush),       32'(e_if));
    chk("id_flush",       32'(id_flush),       32'(e_fl));
    chk("ex_flush",       32'(ex_flush),       32'(e_fl));
    chk("me_wb_flush",    32'(me_wb_flush),    32'(e_fl));
    chk("trap_wr_csr",    32'(trap_wr_csr),    32'(e_wr));
    chk("trap_waddr_csr", 32'(trap_waddr_csr), 32'(e_addr));
    chk("trap_wdata_csr", trap_wdata_csr,      e_data);
    chk("pc_redirect",    32'(pc_redirect),    32'(e_redir));
    chk("redirect_pc",    redirect_pc,         e_rpc);
    chk("drain_timeout",  32'(drain_timeout),  32'(m_timeout));
    chk("busy",           32'(busy),           32'(e_busy));
`ifdef TRAP_CNT_EN
    chk("trap_count",     trap_count,          m_count);
`endif
    if (rst) begin
      if (steps.size() == 0) begin
        if (me_exc_valid)            plan(1'b1, me_pc, {27'b0, me_exc_cause});
        else if (irq_ext && irq_en)  plan(1'b1, me_pc, 32'h8000_000B);
        else if (me_mret)            plan(1'b0, '0, '0);
      end else if (steps[0] == ST_DRAIN) begin
        m_drain_n++;
        if (!mem_busy) begin
          step_done();
        end else if (m_drain_n >= DRAIN_MAX) begin
          m_timeout = 1'b1;
          step_done();
        end
      end else begin
        step_done();
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt();
    tick();
    @(negedge clk);
  endtask

  task automatic exc_event(input logic [4:0] c, input logic [31:0] pc);
    me_exc_valid = 1'b1;
    me_exc_cause = c;
    me_pc        = pc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1;
    me_exc_valid = 1'b0; me_exc_cause = '0; me_pc = '0; me_mret = 1'b0;
    irq_ext = 1'b0; irq_en = 1'b0; mem_busy = 1'b0;
    csr_mtvec = 32'h203; csr_mepc = 32'h1A4;
    #1 rst = 1'b0;
    #1;
    chk("rst_busy",      32'(busy),          0);
    chk("rst_stall",     32'(stall_all),     0);
    chk("rst_wr",        32'(trap_wr_csr),   0);
    chk("rst_timeout",   32'(drain_timeout), 0);
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();

    // Exception, no drain: flush c2, mepc c3, mcause c4, redirect c5.
    exc_event(5'd2, 32'h100);
    tick(); me_exc_valid = 1'b0;
    nxt();
    chk("t1_c2_if_flush", 32'(if_flush), 1);
    chk("t1_c2_id_flush", 32'(id_flush), 1);
    chk("t1_c2_ex_flush", 32'(ex_flush), 1);
    chk("t1_c2_me_wb",    32'(me_wb_flush), 1);
    nxt();
    chk("t1_c3_wr",    32'(trap_wr_csr), 1);
    chk("t1_c3_addr",  32'(trap_waddr_csr), 32'h341);
    chk("t1_c3_data",  trap_wdata_csr, 32'h100);
    nxt();
    chk("t1_c4_addr",  32'(trap_waddr_csr), 32'h342);
    chk("t1_c4_data",  trap_wdata_csr, 32'h2);
    nxt();
    chk("t1_c5_redir", 32'(pc_redirect), 1);
    chk("t1_c5_pc",    redirect_pc, 32'h200);
    nxt();
    chk("t1_c6_busy",  32'(busy), 0);
    tick();

    // Drain: mem_busy held for cycles 0..2, DRAIN spans c1..c3, flush c4.
    exc_event(5'd2, 32'h140);
    mem_busy = 1'b1;
    tick(); me_exc_valid = 1'b0;
    tick();
    tick(); mem_busy = 1'b0;
    @(negedge clk);
    chk("t2_c3_stall",   32'(stall_all), 1);
    chk("t2_c3_noflush", 32'(if_flush), 0);
    nxt();
    chk("t2_c4_flush",   32'(me_wb_flush), 1);
    chk("t2_c4_timeout", 32'(drain_timeout), 0);
    nxt();
    chk("t2_c5_data",    trap_wdata_csr, 32'h140);
    nxt(); nxt();
    chk("t2_c7_pc",      redirect_pc, 32'h200);
    tick();

    // Drain timeout: mem_busy stuck, DRAIN c1..c15, flush c16.
    exc_event(5'd4, 32'h180);
    mem_busy = 1'b1;
    tick(); me_exc_valid = 1'b0;
    repeat (14) tick();
    @(negedge clk);
    chk("t3_c15_stall",   32'(stall_all), 1);
    chk("t3_c15_timeout", 32'(drain_timeout), 0);
    nxt();
    chk("t3_c16_flush",   32'(if_flush), 1);
    chk("t3_c16_timeout", 32'(drain_timeout), 1);
    tick(); mem_busy = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t3_c20_busy",    32'(busy), 0);
    chk("t3_c20_sticky",  32'(drain_timeout), 1);
    tick();

    // MRET: flush c2, redirect to mepc c3, no CSR write. Held an extra
    // cycle to show it is ignored while busy.
    me_mret = 1'b1;
    tick();
    tick(); me_mret = 1'b0;
    @(negedge clk);
    chk("t4_c2_flush", 32'(ex_flush), 1);
    chk("t4_c2_wr",    32'(trap_wr_csr), 0);
    nxt();
    chk("t4_c3_redir", 32'(pc_redirect), 1);
    chk("t4_c3_pc",    redirect_pc, 32'h1A4);
    chk("t4_c3_wr",    32'(trap_wr_csr), 0);
    nxt();
    chk("t4_c4_busy",  32'(busy), 0);
    tick();

    // Priority: exception wins; the held irq then traps on its own.
    exc_event(5'd2, 32'h300);
    irq_ext = 1'b1; irq_en = 1'b1; me_mret = 1'b1;
    tick(); me_exc_valid = 1'b0; me_mret = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_c4_addr",  32'(trap_waddr_csr), 32'h342);
    chk("t5_c4_cause", trap_wdata_csr, 32'h2);
    nxt();
    chk("t5_c5_pc",    redirect_pc, 32'h200);
    tick();
    tick(); irq_ext = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_c10_addr",  32'(trap_waddr_csr), 32'h342);
    chk("t5_c10_cause", trap_wdata_csr, 32'h8000_000B);
    nxt();
    chk("t5_c11_redir", 32'(pc_redirect), 1);
    nxt();
`ifdef TRAP_CNT_EN
    chk("t5_trap_count", trap_count, 32'd5);
`endif
    tick();

    // Masked interrupt does nothing.
    irq_ext = 1'b1; irq_en = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("t6_masked_busy", 32'(busy), 0);
    tick(); irq_ext = 1'b0;

    // Reset during SAVE_EPC: outputs drop at once, no mcause write after.
    exc_event(5'd7, 32'h3C0);
    tick(); me_exc_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("t7_c3_addr", 32'(trap_waddr_csr), 32'h341);
    #2 rst = 1'b0;
    #1;
    chk("t7_async_wr",      32'(trap_wr_csr), 0);
    chk("t7_async_addr",    32'(trap_waddr_csr), 0);
    chk("t7_async_data",    trap_wdata_csr, 0);
    chk("t7_async_stall",   32'(stall_all), 0);
    chk("t7_async_busy",    32'(busy), 0);
    chk("t7_async_timeout", 32'(drain_timeout), 0);
    tick();
    tick(); rst = 1'b1;
    @(negedge clk);
    chk("t7_after_busy", 32'(busy), 0);
    repeat (4) nxt();
    chk("t7_no_wr", 32'(trap_wr_csr), 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_seq_ctrl.md
Name: trap_seq_ctrl

Overview:
- Pipeline-level exception and trap sequencer for the 5-stage RISC-V core.
- Receives synchronous exceptions, MRET and the external interrupt from the MEM stage.
- Drains the outstanding data access, issues flushes to all pipeline registers (including the MEM/WB flush), and writes mepc/mcause through the WB-stage CSR write path.
- Redirects the PC to mtvec, or to mepc for MRET.

Parameters:
- DRAIN_MAX, 15: maximum cycles spent waiting for mem_busy to drop before proceeding.
- CSR_MEPC, 12'h341: CSR address used for the mepc write.
- CSR_MCAUSE, 12'h342: CSR address used for the mcause write.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- me_exc_valid  in  1  synchronous exception present in MEM
- me_exc_cause  in  5  exception code
- me_pc  in  32  PC of the MEM-stage instruction
- me_mret  in  1  MRET in MEM
- irq_ext  in  1  external interrupt request, level-sensitive
- irq_en  in  1  mstatus.MIE
- mem_busy  in  1  data memory access outstanding
- csr_mtvec  in  32  current mtvec
- csr_mepc  in  32  current mepc
- stall_all  out  1  freeze all pipeline registers
- if_flush, id_flush, ex_flush, me_wb_flush  out  1 each  pipeline register flushes
- trap_wr_csr  out  1  CSR write strobe
- trap_waddr_csr  out  12  CSR write address
- trap_wdata_csr  out  32  CSR write data
- pc_redirect  out  1  load redirect_pc into the PC
- redirect_pc  out  32  redirect target
- drain_timeout  out  1  sticky flag: drain gave up
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM enters IDLE.
  - All outputs are 0.
  - Internal epc/cause/kind registers and the drain counter are cleared.
  - Reset asserted mid-sequence aborts the sequence immediately; no partial CSR write completes afterwards.
- FSM states: IDLE, DRAIN, FLUSH, SAVE_EPC, SAVE_CAUSE, REDIRECT.
- IDLE, event capture (priority me_exc_valid > (irq_ext & irq_en) > me_mret):
  - Exception: capture epc=me_pc and cause={27'b0, me_exc_cause}; kind=TRAP.
  - Interrupt: capture epc=me_pc and cause=32'h8000000B; kind=TRAP.
  - MRET: kind=RET.
  - Any event moves to DRAIN.
  - Lower-priority events in the same cycle are dropped. A still-asserted irq is re-sampled on a later return to IDLE.
- DRAIN:
  - stall_all=1.
  - Leave for FLUSH when mem_busy=0, or when the counter reaches DRAIN_MAX. The timeout case also sets drain_timeout, which stays set until reset.
  - The counter clears on entry.
  - With mem_busy=0 on entry, DRAIN lasts exactly 1 cycle.
- FLUSH:
  - 1 cycle; if_flush = id_flush = ex_flush = me_wb_flush = 1; stall_all=0.
  - kind=TRAP goes to SAVE_EPC; kind=RET goes to REDIRECT.
- SAVE_EPC:
  - trap_wr_csr=1, trap_waddr_csr=CSR_MEPC, trap_wdata_csr=epc.
  - stall_all=1; then go to SAVE_CAUSE.
- SAVE_CAUSE:
  - trap_wr_csr=1, trap_waddr_csr=CSR_MCAUSE, trap_wdata_csr=cause.
  - stall_all=1; then go to REDIRECT.
- REDIRECT:
  - pc_redirect=1.
  - redirect_pc = {csr_mtvec[31:2], 2'b00} for TRAP, or csr_mepc for RET.
  - if_flush=1; then go to IDLE.
- Outputs are Moore-style, decoded from the registered state.
  - trap_waddr_csr/trap_wdata_csr are 0 whenever trap_wr_csr=0.
  - redirect_pc is 0 whenever pc_redirect=0.
- Latency, event to pc_redirect, with mem_busy=0:
  - TRAP: 5 cycles (DRAIN, FLUSH, SAVE_EPC, SAVE_CAUSE, REDIRECT).
  - RET: 3 cycles.
- Events arriving while busy=1 are ignored. Upstream flush guarantees that no valid MEM instruction is presented during the sequence.
- busy=1 in every state except IDLE.

Optional Feature:
- Macro TRAP_CNT_EN.
- When defined:
  - Adds output trap_count (32 bits), reset to 0.
  - Increments by 1 on each entry into REDIRECT with kind=TRAP, wrapping from 32'hFFFFFFFF to 0.
  - RET does not count.
- When undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Exception, no drain: me_exc_valid=1, me_exc_cause=2, me_pc=32'h100, mtvec=32'h203, mem_busy=0.
  - Cycle 2: four flushes.
  - Cycle 3: write 341 <- 32'h100.
  - Cycle 4: write 342 <- 32'h2.
  - Cycle 5: pc_redirect, redirect_pc=32'h200.
- Drain: same exception with mem_busy held 3 cycles.
  - DRAIN lasts 3 cycles; the flush is delayed by 2 cycles; drain_timeout=0.
- Drain timeout: mem_busy stuck at 1.
  - Proceeds after DRAIN_MAX=15 cycles; drain_timeout=1 and stays 1.
- MRET: me_mret=1, csr_mepc=32'h1A4.
  - Flush on cycle 2; redirect to 32'h1A4 on cycle 3; no CSR write.
- Priority: me_exc_valid=1, irq_ext=1, irq_en=1 and me_mret=1 in the same cycle.
  - mcause write = 32'h2.
  - After return, with irq still high, a second trap occurs with mcause=32'h8000000B.
- Reset mid-sequence: assert rst=0 during SAVE_EPC.
  - All outputs drop to 0 asynchronously; no mcause write follows.
  - busy=0 after reset release.
